// File: rtl/alu_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int DIV_REG_WIDTH = 16;
  localparam int DIV_CNT_W     = $clog2(DIV_REG_WIDTH);

endpackage

// File: rtl/alu_div_seq_if.sv
// Operand/result handshake bundle between the ALU and the sequential divider.
interface alu_div_seq_if #(
  parameter int REG_WIDTH = 16
);

  logic                 i_valid;
  logic                 i_ready;
  logic [REG_WIDTH-1:0] dividend;
  logic [REG_WIDTH-1:0] divisor;
  logic                 signed_en;
  logic                 o_valid;
  logic                 o_ready;
  logic [REG_WIDTH-1:0] quotient;
  logic [REG_WIDTH-1:0] remainder;
  logic                 div_by_zero;

  modport master (
    output i_valid, dividend, divisor, signed_en, o_ready,
    input  i_ready, o_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  i_valid, dividend, divisor, signed_en, o_ready,
    output i_ready, o_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/alu_div_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and the result sign fix.
module alu_div_negate #(
  parameter int REG_WIDTH = 16
) (
  input  logic [REG_WIDTH-1:0] in,
  input  logic                 en,
  output logic [REG_WIDTH-1:0] out
);

  assign out = en ? (~in + REG_WIDTH'(1)) : in;

endmodule

// File: rtl/alu_div_seq.sv
// Iterative restoring divider: one quotient bit per clock, signed via magnitude + sign fix.
//   state | meaning
//   IDLE  | ready for operands, i_ready high
//   CALC  | one restoring step per cycle, REG_WIDTH cycles
//   DONE  | result held with o_valid until o_ready
module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int REG_WIDTH = DIV_REG_WIDTH
) (
  input logic         clk,
  input logic         reset,
  alu_div_seq_if.slave bus
);

  localparam int W     = REG_WIDTH;
  localparam int CNT_W = (REG_WIDTH == DIV_REG_WIDTH) ? DIV_CNT_W : $clog2(REG_WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     part_q, part_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dbz_q, dbz_d;

  logic [W-1:0]     dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic [W-1:0]     quo_next, part_next;
  logic [W:0]       shifted, trial;

  alu_div_negate #(.REG_WIDTH(W)) u_neg_dvd (
    .in(bus.dividend), .en(bus.signed_en & bus.dividend[W-1]), .out(dvd_mag));
  alu_div_negate #(.REG_WIDTH(W)) u_neg_dvs (
    .in(bus.divisor), .en(bus.signed_en & bus.divisor[W-1]), .out(dvs_mag));

  // Dividend register doubles as the quotient shift register.
  assign shifted   = {part_q, dvd_q[W-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign quo_next  = {dvd_q[W-2:0], ~trial[W]};
  assign part_next = trial[W] ? shifted[W-1:0] : trial[W-1:0];

  alu_div_negate #(.REG_WIDTH(W)) u_neg_quo (
    .in(quo_next), .en(sgn_q & (neg_a_q ^ neg_b_q)), .out(quo_fix));
  alu_div_negate #(.REG_WIDTH(W)) u_neg_rem (
    .in(part_next), .en(sgn_q & neg_a_q), .out(rem_fix));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          sgn_d   = bus.signed_en;
          neg_a_d = bus.dividend[W-1];
          neg_b_d = bus.divisor[W-1];
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
          part_d  = '0;
          cnt_d   = CNT_W'(W - 1);
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        dvd_d  = quo_next;
        part_d = part_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = quo_fix;
          rem_d   = rem_fix;
        end
      end
      DONE: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.i_ready     = (state_q == IDLE);
  assign bus.o_valid     = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Randomized and directed checks of alu_div_seq against an arithmetic reference model.
module tb_alu_div_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_div_seq_if #(.REG_WIDTH(W)) bus ();

  alu_div_seq #(.REG_WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
      return;
    end
    z = 1'b0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = W'(sa / sb);
    r = W'(sa % sb);
  endfunction

  // Presents one operation, returns edges from accept to o_valid and the held result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit rdy,
                       output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                       output bit z, output int busy_hi);
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.signed_en = s;
    bus.o_ready   = rdy;
    @(posedge clk); #1;
    bus.i_valid   = 1'b0;
    bus.dividend  = W'($urandom);
    bus.divisor   = W'($urandom);
    bus.signed_en = 1'($urandom);
    lat = 0;
    busy_hi = 0;
    while (!bus.o_valid && lat < 64) begin
      if (bus.i_ready) busy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.i_ready) busy_hi++;
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_valid = 1'b0; bus.o_ready = 1'b0; bus.signed_en = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready got %b exp 1", bus.i_ready); end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b exp 0", bus.o_valid); end
    n_checks++; if (bus.quotient !== '0) begin n_fail++; $display("FAIL reset_quotient got %h exp 0", bus.quotient); end
    n_checks++; if (bus.remainder !== '0) begin n_fail++; $display("FAIL reset_remainder got %h exp 0", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b exp 0", bus.div_by_zero); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    int lat, busy; logic [W-1:0] q, r; bit z;
    issue(16'd100, 16'd7, 1'b0, 1'b1, lat, q, r, z, busy);
    n_checks++; if (lat != W) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", lat, W); end
    n_checks++; if (busy != 0) begin n_fail++; $display("FAIL basic_i_ready_busy got %0d high samples exp 0", busy); end
    n_checks++; if (q !== 16'd14) begin n_fail++; $display("FAIL basic_quotient got %0d exp 14", q); end
    n_checks++; if (r !== 16'd2) begin n_fail++; $display("FAIL basic_remainder got %0d exp 2", r); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b exp 0", z); end
    @(posedge clk); #1;
    n_checks++; if (bus.o_valid !== 1'b0 || bus.i_ready !== 1'b1)
      begin n_fail++; $display("FAIL basic_return_idle got o_valid=%b i_ready=%b exp 0/1", bus.o_valid, bus.i_ready); end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta [2] = '{16'hFFF9, 16'h0007};
    logic [W-1:0] tb [2] = '{16'h0002, 16'hFFFE};
    logic [W-1:0] tq [2] = '{16'hFFFD, 16'hFFFD};
    logic [W-1:0] tr [2] = '{16'hFFFF, 16'h0001};
    int lat, busy; logic [W-1:0] q, r; bit z;
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], 1'b1, 1'b1, lat, q, r, z, busy);
      n_checks++; if (q !== tq[i]) begin n_fail++; $display("FAIL signed_quotient[%0d] got %h exp %h", i, q, tq[i]); end
      n_checks++; if (r !== tr[i]) begin n_fail++; $display("FAIL signed_remainder[%0d] got %h exp %h", i, r, tr[i]); end
      n_checks++; if (lat != W) begin n_fail++; $display("FAIL signed_latency[%0d] got %0d exp %0d", i, lat, W); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat, busy; logic [W-1:0] q, r; bit z;
    for (int s = 0; s < 2; s++) begin
      issue(16'h1234, 16'h0000, 1'(s), 1'b1, lat, q, r, z, busy);
      n_checks++; if (lat != 0) begin n_fail++; $display("FAIL dbz_latency[s=%0d] got %0d exp 0", s, lat); end
      n_checks++; if (q !== 16'hFFFF) begin n_fail++; $display("FAIL dbz_quotient[s=%0d] got %h exp FFFF", s, q); end
      n_checks++; if (r !== 16'h1234) begin n_fail++; $display("FAIL dbz_remainder[s=%0d] got %h exp 1234", s, r); end
      n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL dbz_flag[s=%0d] got %b exp 1", s, z); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] ta [7] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h0005, 16'h1234, 16'h8000, 16'h8000};
    logic [W-1:0] tb [7] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0009, 16'h1234, 16'h8000, 16'h0001};
    bit           ts [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] tq [7] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h8000};
    logic [W-1:0] tr [7] = '{16'h0000, 16'h8000, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0000};
    int lat, busy; logic [W-1:0] q, r; bit z;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i], ts[i], 1'b1, lat, q, r, z, busy);
      n_checks++; if (q !== tq[i] || r !== tr[i] || z !== 1'b0)
        begin n_fail++; $display("FAIL boundary[%0d] got q=%h r=%h z=%b exp q=%h r=%h z=0", i, q, r, z, tq[i], tr[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat, busy; logic [W-1:0] q, r; bit z;
    issue(16'd1000, 16'd3, 1'b0, 1'b0, lat, q, r, z, busy);
    n_checks++; if (q !== 16'd333 || r !== 16'd1) begin n_fail++; $display("FAIL bp_result got q=%0d r=%0d exp 333/1", q, r); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.o_valid !== 1'b1 || bus.i_ready !== 1'b0 || bus.quotient !== 16'd333 || bus.remainder !== 16'd1)
        begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b q=%0d r=%0d exp 1/0/333/1", i, bus.o_valid, bus.i_ready, bus.quotient, bus.remainder); end
    end
    @(negedge clk) bus.o_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.o_valid !== 1'b0 || bus.i_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_release got o_valid=%b i_ready=%b exp 0/1", bus.o_valid, bus.i_ready); end
    issue(16'd50, 16'd6, 1'b0, 1'b1, lat, q, r, z, busy);
    n_checks++; if (q !== 16'd8 || r !== 16'd2) begin n_fail++; $display("FAIL bp_next got q=%0d r=%0d exp 8/2", q, r); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, busy; logic [W-1:0] q, r; bit z;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.dividend = 16'd40000; bus.divisor = 16'd7; bus.signed_en = 1'b0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.i_ready !== 1'b1 || bus.o_valid !== 1'b0)
      begin n_fail++; $display("FAIL midreset_hs got i_ready=%b o_valid=%b exp 1/0", bus.i_ready, bus.o_valid); end
    n_checks++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs got q=%h r=%h z=%b exp 0", bus.quotient, bus.remainder, bus.div_by_zero); end
    @(negedge clk) reset = 1'b0;
    issue(16'd9, 16'd3, 1'b0, 1'b1, lat, q, r, z, busy);
    n_checks++; if (q !== 16'd3 || r !== 16'd0 || lat != W)
      begin n_fail++; $display("FAIL midreset_next got q=%0d r=%0d lat=%0d exp 3/0/%0d", q, r, lat, W); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, busy; logic [W-1:0] q, r, eq, er; bit z, ez;
    logic [W-1:0] a, b; bit s, rdy;
    for (int i = 0; i < 300; i++) begin
      a   = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        3:       b = 16'hFFFF;
        default: b = W'($urandom);
      endcase
      s   = 1'($urandom);
      rdy = 1'($urandom);
      model(a, b, s, eq, er, ez);
      issue(a, b, s, rdy, lat, q, r, z, busy);
      n_checks++; if (q !== eq || r !== er || z !== ez)
        begin n_fail++; $display("FAIL rand[%0d] %h/%h s=%b got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, a, b, s, q, r, z, eq, er, ez); end
      n_checks++; if (lat != (ez ? 0 : W) || busy != 0)
        begin n_fail++; $display("FAIL rand_timing[%0d] got lat=%0d busy=%0d exp lat=%0d busy=0", i, lat, busy, ez ? 0 : W); end
      if (!rdy) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk) bus.o_ready = 1'b1;
      end
      @(posedge clk); #1;
      n_checks++; if (bus.i_ready !== 1'b1 || bus.o_valid !== 1'b0)
        begin n_fail++; $display("FAIL rand_idle[%0d] got i_ready=%b o_valid=%b exp 1/0", i, bus.i_ready, bus.o_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
